// File: rtl/calc_pkg.sv
// Shared calculator types: front-end FSM states, keypad operator codes, entry magnitude limits.
// Used by the operand builder and the keypad scanner.
package calc_pkg;

   typedef enum logic [1:0] {
      ENTER_A     = 2'd0,
      ENTER_B     = 2'd1,
      CALC_REQ    = 2'd2,
      SHOW_RESULT = 2'd3
   } state_t;

   localparam logic [2:0] OP_NONE = 3'b000;
   localparam logic [2:0] OP_NEG  = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_MUL  = 3'b100;

   localparam int MAG_W     = 15;
   localparam int MAG_LIMIT = 32767;

   function automatic logic is_arith(input logic [2:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
   endfunction

endpackage

// File: rtl/dec_accum.sv
// Decimal entry accumulator: next_mag = mag*10 + digit, ovf when that exceeds the magnitude limit.
// Purely combinational, zero latency, no flow control.
module dec_accum
   import calc_pkg::*;
(
   input  logic [MAG_W-1:0] mag,
   input  logic [3:0]       digit,
   output logic [MAG_W-1:0] next_mag,
   output logic             ovf
);

   logic [MAG_W+3:0] sum;

   always_comb begin
      sum      = {4'd0, mag} * (MAG_W+4)'(10) + {{MAG_W{1'b0}}, digit};
      ovf      = sum > (MAG_W+4)'(MAG_LIMIT);
      next_mag = sum[MAG_W-1:0];
   end

endmodule

// File: rtl/operand_builder.sv
// Calculator front end: turns keypad keys into ALU operands, one key per press, effects one cycle after accept.
// Keys stay pending (no key_read) while an ALU request is outstanding; calc_start holds until calc_ack.
module operand_builder
   import calc_pkg::*;
(
   input  logic               clk,
   input  logic               nRST,
   input  logic               read_input,
   input  logic [3:0]         keypad_input,
   input  logic [2:0]         operator_input,
   input  logic               equal_input,
   output logic               key_read,
   output logic               calc_start,
   input  logic               calc_ack,
   input  logic signed [15:0] calc_result,
   output logic signed [15:0] operand_a,
   output logic signed [15:0] operand_b,
   output logic [2:0]         op_code,
   output logic signed [15:0] display_value,
   output logic               entry_err
);

   state_t             state, state_nxt;
   logic               armed, armed_nxt;
   logic               key_read_nxt;
   logic [MAG_W-1:0]   mag, mag_nxt;
   logic               neg, neg_nxt;
   logic               has_dig, has_dig_nxt;
   logic signed [15:0] opa_nxt, opb_nxt;
   logic [2:0]         op_nxt;
   logic signed [15:0] result, result_nxt;
   logic               err_nxt;

   logic               accept, is_eq, is_op, is_dig;
   logic signed [15:0] entry_val;
   logic [MAG_W-1:0]   acc_mag;
   logic               acc_ovf;

   dec_accum u_dec_accum (
      .mag      (mag),
      .digit    (keypad_input),
      .next_mag (acc_mag),
      .ovf      (acc_ovf)
   );

   assign calc_start = (state == CALC_REQ);

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         state     <= ENTER_A;
         armed     <= 1'b0;
         key_read  <= 1'b0;
         mag       <= '0;
         neg       <= 1'b0;
         has_dig   <= 1'b0;
         operand_a <= '0;
         operand_b <= '0;
         op_code   <= OP_NONE;
         result    <= '0;
         entry_err <= 1'b0;
      end else begin
         state     <= state_nxt;
         armed     <= armed_nxt;
         key_read  <= key_read_nxt;
         mag       <= mag_nxt;
         neg       <= neg_nxt;
         has_dig   <= has_dig_nxt;
         operand_a <= opa_nxt;
         operand_b <= opb_nxt;
         op_code   <= op_nxt;
         result    <= result_nxt;
         entry_err <= err_nxt;
      end
   end

   always_comb begin
      accept    = read_input && armed && (state != CALC_REQ);
      is_eq     = equal_input;
      is_op     = !equal_input && (operator_input != OP_NONE);
      is_dig    = !is_eq && !is_op;
      entry_val = neg ? -$signed({1'b0, mag}) : $signed({1'b0, mag});

      state_nxt    = state;
      key_read_nxt = accept;
      mag_nxt      = mag;
      neg_nxt      = neg;
      has_dig_nxt  = has_dig;
      opa_nxt      = operand_a;
      opb_nxt      = operand_b;
      op_nxt       = op_code;
      result_nxt   = result;
      err_nxt      = entry_err;

      // Re-arm only once the key has been seen released, so a held key is taken once.
      if (!read_input)
         armed_nxt = 1'b1;
      else if (accept)
         armed_nxt = 1'b0;
      else
         armed_nxt = armed;

      if (accept && (is_eq || is_op))
         err_nxt = 1'b0;

      case (state)
         ENTER_A, ENTER_B: begin
            if (accept && is_dig) begin
               if (acc_ovf) begin
                  err_nxt = 1'b1;
               end else begin
                  mag_nxt     = acc_mag;
                  has_dig_nxt = 1'b1;
               end
            end else if (accept && is_op && operator_input == OP_NEG) begin
               neg_nxt = !neg;
            end else if (accept && is_op && is_arith(operator_input)) begin
               if (state == ENTER_A) begin
                  opa_nxt     = entry_val;
                  op_nxt      = operator_input;
                  mag_nxt     = '0;
                  neg_nxt     = 1'b0;
                  has_dig_nxt = 1'b0;
                  state_nxt   = ENTER_B;
               end else if (!has_dig) begin
                  op_nxt = operator_input;
               end
            end else if (accept && is_eq && state == ENTER_B) begin
               opb_nxt     = entry_val;
               mag_nxt     = '0;
               neg_nxt     = 1'b0;
               has_dig_nxt = 1'b0;
               state_nxt   = CALC_REQ;
            end
         end
         CALC_REQ: begin
            if (calc_ack) begin
               result_nxt = calc_result;
               state_nxt  = SHOW_RESULT;
            end
         end
         SHOW_RESULT: begin
            if (accept && is_dig) begin
               opa_nxt     = '0;
               mag_nxt     = {{(MAG_W-4){1'b0}}, keypad_input};
               neg_nxt     = 1'b0;
               has_dig_nxt = 1'b1;
               state_nxt   = ENTER_A;
            end else if (accept && is_op && is_arith(operator_input)) begin
               opa_nxt     = result;
               op_nxt      = operator_input;
               mag_nxt     = '0;
               neg_nxt     = 1'b0;
               has_dig_nxt = 1'b0;
               state_nxt   = ENTER_B;
            end
         end
         default: state_nxt = ENTER_A;
      endcase
   end

   always_comb begin
      case (state)
         CALC_REQ:    display_value = operand_b;
         SHOW_RESULT: display_value = result;
         default:     display_value = entry_val;
      endcase
   end

endmodule

// File: tb/tb_operand_builder.sv
// Self-checking bench for operand_builder: vector table, directed corner sequences, random keys vs a key-level model.
module tb_operand_builder;

   localparam int K_DIG = 0;
   localparam int K_OP  = 1;
   localparam int K_EQ  = 2;

   localparam int S_A = 0;
   localparam int S_B = 1;
   localparam int S_C = 2;
   localparam int S_S = 3;

   logic               clk;
   logic               nRST;
   logic               read_input;
   logic [3:0]         keypad_input;
   logic [2:0]         operator_input;
   logic               equal_input;
   logic               key_read;
   logic               calc_start;
   logic               calc_ack;
   logic signed [15:0] calc_result;
   logic signed [15:0] operand_a;
   logic signed [15:0] operand_b;
   logic [2:0]         op_code;
   logic signed [15:0] display_value;
   logic               entry_err;

   int checks = 0;
   int errors = 0;

   // key-level reference model
   int m_state, m_mag, m_neg, m_dig, m_a, m_b, m_op, m_res, m_err;

   typedef struct {
      int kind;
      int val;
      int disp;
      int err;
      int opa;
      int opb;
      int op;
      int start;
   } vec_t;

   vec_t vecs[12];

   operand_builder dut (
      .clk            (clk),
      .nRST           (nRST),
      .read_input     (read_input),
      .keypad_input   (keypad_input),
      .operator_input (operator_input),
      .equal_input    (equal_input),
      .key_read       (key_read),
      .calc_start     (calc_start),
      .calc_ack       (calc_ack),
      .calc_result    (calc_result),
      .operand_a      (operand_a),
      .operand_b      (operand_b),
      .op_code        (op_code),
      .display_value  (display_value),
      .entry_err      (entry_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_state = S_A; m_mag = 0; m_neg = 0; m_dig = 0;
      m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_err = 0;
   endtask

   function automatic int m_entry();
      return m_neg ? -m_mag : m_mag;
   endfunction

   function automatic int m_disp();
      if (m_state == S_C) return m_b;
      if (m_state == S_S) return m_res;
      return m_entry();
   endfunction

   task automatic model_clear_entry();
      m_mag = 0; m_neg = 0; m_dig = 0;
   endtask

   task automatic model_key(input int kind, input int v);
      bit arith;
      arith = (kind == K_OP) && (v >= 2) && (v <= 4);
      if (kind != K_DIG) m_err = 0;
      if (m_state == S_A || m_state == S_B) begin
         if (kind == K_DIG) begin
            if (m_mag * 10 + v > 32767) m_err = 1;
            else begin m_mag = m_mag * 10 + v; m_dig = 1; end
         end else if (kind == K_OP && v == 1) begin
            m_neg = !m_neg;
         end else if (arith && m_state == S_A) begin
            m_a = m_entry(); m_op = v; model_clear_entry(); m_state = S_B;
         end else if (arith && !m_dig) begin
            m_op = v;
         end else if (kind == K_EQ && m_state == S_B) begin
            m_b = m_entry(); model_clear_entry(); m_state = S_C;
         end
      end else if (m_state == S_S) begin
         if (kind == K_DIG) begin
            m_a = 0; m_mag = v; m_neg = 0; m_dig = 1; m_state = S_A;
         end else if (arith) begin
            m_a = m_res; m_op = v; model_clear_entry(); m_state = S_B;
         end
      end
   endtask

   task automatic do_reset();
      nRST = 1'b0;
      read_input = 1'b0; keypad_input = '0; operator_input = '0; equal_input = 1'b0;
      calc_ack = 1'b0; calc_result = '0;
      repeat (2) @(posedge clk);
      #1 nRST = 1'b1;
      @(posedge clk); #1;
      model_reset();
   endtask

   task automatic press(input int kind, input int v);
      bit seen;
      keypad_input   = (kind == K_DIG) ? 4'(v) : 4'd0;
      operator_input = (kind == K_OP) ? 3'(v) : 3'd0;
      equal_input    = (kind == K_EQ);
      read_input     = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(posedge clk); #1;
         if (key_read) seen = 1'b1;
      end
      if (!seen) chk("key_ack_timeout", 0, 1);
      read_input = 1'b0; operator_input = '0; equal_input = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic ack(input int r);
      calc_ack = 1'b1;
      calc_result = 16'(r);
      @(posedge clk); #1;
      calc_ack = 1'b0;
   endtask

   task automatic check_model();
      chk("rand_opa", operand_a, m_a);
      chk("rand_opb", operand_b, m_b);
      chk("rand_op", op_code, m_op);
      chk("rand_disp", display_value, m_disp());
      chk("rand_err", entry_err, m_err);
      chk("rand_start", calc_start, (m_state == S_C) ? 1 : 0);
   endtask

   initial begin
      int pulses;
      shortint rr;

      vecs[0]  = '{K_DIG, 3, 3,    0, 0,    0,  0, 0};
      vecs[1]  = '{K_DIG, 2, 32,   0, 0,    0,  0, 0};
      vecs[2]  = '{K_DIG, 7, 327,  0, 0,    0,  0, 0};
      vecs[3]  = '{K_DIG, 6, 3276, 0, 0,    0,  0, 0};
      vecs[4]  = '{K_DIG, 8, 3276, 1, 0,    0,  0, 0};
      vecs[5]  = '{K_DIG, 9, 3276, 1, 0,    0,  0, 0};
      vecs[6]  = '{K_OP,  2, 0,    0, 3276, 0,  2, 0};
      vecs[7]  = '{K_OP,  1, 0,    0, 3276, 0,  2, 0};
      vecs[8]  = '{K_OP,  3, 0,    0, 3276, 0,  3, 0};
      vecs[9]  = '{K_DIG, 5, -5,   0, 3276, 0,  3, 0};
      vecs[10] = '{K_OP,  2, -5,   0, 3276, 0,  3, 0};
      vecs[11] = '{K_EQ,  0, -5,   0, 3276, -5, 3, 1};

      // reset values, checked while reset is still asserted
      nRST = 1'b0;
      read_input = 1'b0; keypad_input = '0; operator_input = '0; equal_input = 1'b0;
      calc_ack = 1'b0; calc_result = '0;
      #12;
      chk("rst_key_read", key_read, 0);
      chk("rst_calc_start", calc_start, 0);
      chk("rst_opa", operand_a, 0);
      chk("rst_opb", operand_b, 0);
      chk("rst_op", op_code, 0);
      chk("rst_disp", display_value, 0);
      chk("rst_err", entry_err, 0);

      // vector table: overflow rejection, sign, op replacement, no chaining
      do_reset();
      for (int i = 0; i < 12; i++) begin
         press(vecs[i].kind, vecs[i].val);
         chk($sformatf("vec%0d_disp", i), display_value, vecs[i].disp);
         chk($sformatf("vec%0d_err", i), entry_err, vecs[i].err);
         chk($sformatf("vec%0d_opa", i), operand_a, vecs[i].opa);
         chk($sformatf("vec%0d_opb", i), operand_b, vecs[i].opb);
         chk($sformatf("vec%0d_op", i), op_code, vecs[i].op);
         chk($sformatf("vec%0d_start", i), calc_start, vecs[i].start);
      end

      // 1 2 + 3 = , ALU answers 15; then SHOW_RESULT continuations
      do_reset();
      press(K_DIG, 1); press(K_DIG, 2); press(K_OP, 2); press(K_DIG, 3); press(K_EQ, 0);
      repeat (4) @(posedge clk);
      #1 chk("basic_start_held", calc_start, 1);
      chk("basic_disp_opb", display_value, 3);
      ack(15);
      chk("basic_opa", operand_a, 12);
      chk("basic_op", op_code, 2);
      chk("basic_opb", operand_b, 3);
      chk("basic_start_drop", calc_start, 0);
      chk("basic_disp", display_value, 15);
      press(K_OP, 4);
      chk("show_mul_opa", operand_a, 15);
      chk("show_mul_op", op_code, 4);
      chk("show_mul_disp", display_value, 0);
      press(K_DIG, 2); press(K_EQ, 0);
      chk("show_mul_inb", calc_start, 1);
      ack(15);
      press(K_DIG, 4);
      chk("show_dig_opa", operand_a, 0);
      chk("show_dig_disp", display_value, 4);
      press(K_OP, 2);
      chk("show_dig_entry", operand_a, 4);

      // a key held for 20 cycles is consumed once
      do_reset();
      keypad_input = 4'd7; read_input = 1'b1;
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (key_read) pulses++;
      end
      chk("hold_pulses", pulses, 1);
      chk("hold_disp", display_value, 7);
      read_input = 1'b0;
      @(posedge clk); #1;
      press(K_DIG, 7);
      chk("hold_repress", display_value, 77);

      // 5 +/- - 2 +/- =
      do_reset();
      press(K_DIG, 5); press(K_OP, 1); press(K_OP, 3); press(K_DIG, 2); press(K_OP, 1); press(K_EQ, 0);
      chk("neg_opa", operand_a, -5);
      chk("neg_opb", operand_b, -2);
      chk("neg_op", op_code, 3);

      // key pending in CALC_REQ, ack in the same cycle: taken afterwards from SHOW_RESULT
      do_reset();
      press(K_DIG, 1); press(K_OP, 2); press(K_DIG, 2); press(K_EQ, 0);
      keypad_input = 4'd6; read_input = 1'b1;
      pulses = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         if (key_read) pulses++;
      end
      chk("pend_no_ack", pulses, 0);
      ack(-100);
      chk("pend_same_cycle_kr", key_read, 0);
      chk("pend_same_cycle_disp", display_value, -100);
      @(posedge clk); #1;
      chk("pend_later_kr", key_read, 1);
      chk("pend_later_disp", display_value, 6);
      chk("pend_later_opa", operand_a, 0);
      read_input = 1'b0;
      @(posedge clk); #1;

      // reset in the middle of CALC_REQ with a key held down
      do_reset();
      press(K_DIG, 1); press(K_OP, 4); press(K_DIG, 2); press(K_EQ, 0);
      keypad_input = 4'd9; read_input = 1'b1;
      @(posedge clk); #2;
      nRST = 1'b0;
      #1;
      chk("mid_rst_start", calc_start, 0);
      chk("mid_rst_opa", operand_a, 0);
      chk("mid_rst_opb", operand_b, 0);
      chk("mid_rst_op", op_code, 0);
      chk("mid_rst_disp", display_value, 0);
      chk("mid_rst_err", entry_err, 0);
      @(posedge clk); #1;
      nRST = 1'b1;
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (key_read) pulses++;
      end
      chk("mid_rst_held_key", pulses, 0);
      chk("mid_rst_held_disp", display_value, 0);
      read_input = 1'b0;
      @(posedge clk); #1;
      press(K_DIG, 9);
      chk("mid_rst_after", display_value, 9);

      // random keys and ALU responses against the model
      do_reset();
      for (int n = 0; n < 400; n++) begin
         int pick;
         pick = int'($urandom_range(0, 99));
         rr = shortint'($urandom);
         if (m_state == S_C) begin
            if (pick < 75) begin
               ack(int'(rr));
               m_res = int'(rr);
               m_state = S_S;
            end else begin
               @(posedge clk); #1;
            end
         end else if (pick < 55) begin
            int d;
            d = int'($urandom_range(0, 9));
            press(K_DIG, d);
            model_key(K_DIG, d);
         end else if (pick < 82) begin
            int o;
            o = int'($urandom_range(1, 4));
            press(K_OP, o);
            model_key(K_OP, o);
         end else if (pick < 94) begin
            press(K_EQ, 0);
            model_key(K_EQ, 0);
         end else begin
            ack(int'(rr));
         end
         check_model();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
